// File: rtl/crc_pkg.sv
// crc_pkg: shared CRC preset constants and engine state encoding
package crc_pkg;
  localparam logic [4:0]  CRC5_POLY     = 5'b01001;
  localparam logic [4:0]  CRC5_INIT     = 5'b01001;
  localparam logic [15:0] CRC16_POLY    = 16'h1021;
  localparam logic [15:0] CRC16_INIT    = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUE = 16'h1D0F;
  typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_SHIFTOUT} state_t;
endpackage

// File: rtl/crc_lfsr_step.sv
// crc_lfsr_step: one-bit CRC register update (i_crc, i_bit -> o_crc_next) for generator POLY
import crc_pkg::*;
module crc_lfsr_step #(
  parameter int               WIDTH = 5,
  parameter logic [WIDTH-1:0] POLY  = CRC5_POLY
) (
  input  logic [WIDTH-1:0] i_crc,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_crc_next
);
  logic w_fb;
  assign w_fb       = i_bit ^ i_crc[WIDTH-1];
  assign o_crc_next = {i_crc[WIDTH-2:0], w_fb} ^ ({WIDTH{w_fb}} & {POLY[WIDTH-1:1], 1'b0});
endmodule

// File: rtl/crc_serial_engine.sv
// crc_serial_engine: serial CRC accumulator with MSB-first handshaked output and residue check
// ports: crcclk/reset (sync, high); start, bit_valid/bit_in in; out_start/out_ready -> bit_out/bit_out_valid/out_done; crc, crc_ok, bit_count status
import crc_pkg::*;
module crc_serial_engine #(
  parameter int               WIDTH      = 5,
  parameter logic [WIDTH-1:0] POLY       = CRC5_POLY,
  parameter logic [WIDTH-1:0] INIT       = CRC5_INIT,
  parameter bit               INVERT_OUT = 1'b0,
  parameter logic [WIDTH-1:0] RESIDUE    = '0,
  parameter int               CNT_W      = 8
) (
  input  logic             crcclk,
  input  logic             reset,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             out_start,
  input  logic             out_ready,
  output logic             bit_out,
  output logic             bit_out_valid,
  output logic             out_done,
  output logic [WIDTH-1:0] crc,
  output logic             crc_ok,
  output logic [CNT_W-1:0] bit_count
);
  localparam int OCW = $clog2(WIDTH + 1);
  state_t           r_state, w_state_next;
  logic [WIDTH-1:0] r_crc, w_crc_next, r_sreg, w_sreg_next, w_step;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [OCW-1:0]   r_ocnt, w_ocnt_next;
  logic             r_done, w_done_next, w_fold;
  crc_lfsr_step #(.WIDTH(WIDTH), .POLY(POLY)) u_step (
    .i_crc     (r_crc),
    .i_bit     (bit_in),
    .o_crc_next(w_step)
  );
  assign w_fold = r_state == ST_ACCUM && bit_valid;
  // the snapshot takes w_crc_next so a bit arriving with out_start is folded in first
  always_comb begin
    w_state_next = r_state;
    w_crc_next   = w_fold ? w_step : r_crc;
    w_cnt_next   = (w_fold && r_cnt != '1) ? r_cnt + 1'b1 : r_cnt;
    w_sreg_next  = r_sreg;
    w_ocnt_next  = r_ocnt;
    w_done_next  = 1'b0;
    if (start) begin
      w_state_next = ST_ACCUM;
      w_crc_next   = INIT;
      w_cnt_next   = '0;
    end else if (r_state == ST_ACCUM && out_start) begin
      w_state_next = ST_SHIFTOUT;
      w_sreg_next  = w_crc_next;
      w_ocnt_next  = OCW'(WIDTH);
    end else if (r_state == ST_SHIFTOUT && out_ready) begin
      w_sreg_next = r_sreg << 1;
      w_ocnt_next = r_ocnt - 1'b1;
      if (r_ocnt == OCW'(1)) begin
        w_state_next = ST_ACCUM;
        w_done_next  = 1'b1;
      end
    end
  end
  always_ff @(posedge crcclk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_crc   <= INIT;
      r_cnt   <= '0;
      r_sreg  <= '0;
      r_ocnt  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_crc   <= w_crc_next;
      r_cnt   <= w_cnt_next;
      r_sreg  <= w_sreg_next;
      r_ocnt  <= w_ocnt_next;
      r_done  <= w_done_next;
    end
  end
  assign bit_out_valid = r_state == ST_SHIFTOUT;
  assign bit_out       = bit_out_valid & (r_sreg[WIDTH-1] ^ INVERT_OUT);
  assign out_done      = r_done;
  assign crc           = r_crc;
  assign crc_ok        = r_crc == RESIDUE;
  assign bit_count     = r_cnt;
endmodule
